// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the PC/fetch stage: next-PC select codes and fetch FSM encodings.
// The NPC codes mirror the shared control-encoding definitions used by decode.
package pc_fetch_unit_pkg;

  localparam logic [4:0] NPC_PLUS4  = 5'b00000;
  localparam logic [4:0] NPC_BRANCH = 5'b00001;
  localparam logic [4:0] NPC_JUMP   = 5'b00010;
  localparam logic [4:0] NPC_JALR   = 5'b00100;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC selection: sequential, conditional branch, jump and JALR targets.
// All additions wrap modulo 2^32; JALR clears bit 0 of the computed target.
module npc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [4:0]  NPCOp,
  input  logic        branch_taken,
  input  logic [31:0] immout,
  input  logic [31:0] alu_target,
  output logic [31:0] npc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_imm;

  assign w_pc_plus4 = pc + 32'd4;
  assign w_pc_imm   = pc + immout;

  always_comb begin
    npc = w_pc_plus4;
    case (NPCOp)
      NPC_PLUS4:  npc = w_pc_plus4;
      NPC_BRANCH: npc = branch_taken ? w_pc_imm : w_pc_plus4;
      NPC_JUMP:   npc = w_pc_imm;
      NPC_JALR:   npc = alu_target & ~32'h1;
      default:    npc = w_pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch FSM with req/gnt handshake to instruction memory.
// Optional MISALIGN_TRAP_EN: misaligned next-PC redirects to TRAP_PC with a one-cycle trap pulse.
//
// state  | meaning
// S_BOOT | one idle cycle after reset release
// S_REQ  | request held at pc until imem_gnt; rdata captured into instr
// S_EXEC | instr valid, waiting for commit (stall holds it here)
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC   = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        commit,
  input  logic [4:0]  NPCOp,
  input  logic        branch_taken,
  input  logic [31:0] immout,
  input  logic [31:0] alu_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_trap;

  logic [31:0] w_npc;
  logic [31:0] w_npc_load;
  logic        w_misalign;
  logic [31:0] w_pc_next;

  npc_calc u_npc_calc (
    .pc           (r_pc),
    .NPCOp        (NPCOp),
    .branch_taken (branch_taken),
    .immout       (immout),
    .alu_target   (alu_target),
    .npc          (w_npc)
  );

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = |w_npc[1:0];
  assign w_npc_load = w_npc;
`else
  assign w_misalign = 1'b0;
  assign w_npc_load = align_word(w_npc);
`endif

  assign w_pc_next = w_misalign ? TRAP_PC : w_npc_load;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_trap  <= 1'b0;
    end else begin
      r_trap <= 1'b0;
      case (r_state)
        S_BOOT: r_state <= S_REQ;
        S_REQ: begin
          if (imem_gnt) begin
            r_instr <= imem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // a stalled commit is simply not accepted; it will be presented again
          if (commit && !stall) begin
            r_pc    <= w_pc_next;
            r_trap  <= w_misalign;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == S_EXEC);
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign trap        = r_trap;

endmodule
